mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb.sv | 197 +++++++++++++++++++
 tb/tb_mem_arb.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// mem_arb: arbitrates an instruction-fetch port (IFU) and a load/store port (LSU) onto a
// single downstream memory channel, with at most one transaction in flight.
//
// Ports
//   clk, rst                      clock; synchronous active-low reset
//   ifu_req/ifu_addr              fetch read request (always a full-word read)
//   ifu_gnt/ifu_rvalid/ifu_rdata  fetch accept pulse, response pulse, read data
//   lsu_req/we/addr/wdata/mask    load/store request and payload
//   lsu_gnt/lsu_rvalid/lsu_rdata  load/store accept pulse, response pulse, read data
//   mem_valid/ready/we/addr/wdata/mask  downstream request channel (valid/ready handshake)
//   mem_rvalid/mem_rdata          downstream response; also acknowledges writes
//   err                           one-cycle pulse alongside a response aborted by timeout
//
// Flow: IDLE (grant + latch) -> REQ (hold mem_valid until ready) -> WAIT (count until
// mem_rvalid or TIMEOUT) -> RESP (one-cycle rvalid to the owner) -> IDLE.
// TIMEOUT is the number of WAIT cycles allowed; it must be in 1..255.
module mem_arb #(
    parameter int unsigned TIMEOUT        = 255,
    parameter int unsigned ISA_WIDTH      = 32,
    parameter int unsigned MEM_MASK_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      ifu_req,
    input  logic [ISA_WIDTH-1:0]      ifu_addr,
    output logic                      ifu_gnt,
    output logic                      ifu_rvalid,
    output logic [ISA_WIDTH-1:0]      ifu_rdata,

    input  logic                      lsu_req,
    input  logic                      lsu_we,
    input  logic [ISA_WIDTH-1:0]      lsu_addr,
    input  logic [ISA_WIDTH-1:0]      lsu_wdata,
    input  logic [MEM_MASK_WIDTH-1:0] lsu_mask,
    output logic                      lsu_gnt,
    output logic                      lsu_rvalid,
    output logic [ISA_WIDTH-1:0]      lsu_rdata,

    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic                      mem_we,
    output logic [ISA_WIDTH-1:0]      mem_addr,
    output logic [ISA_WIDTH-1:0]      mem_wdata,
    output logic [MEM_MASK_WIDTH-1:0] mem_mask,
    input  logic                      mem_rvalid,
    input  logic [ISA_WIDTH-1:0]      mem_rdata,

    output logic                      err
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StResp = 2'd3
    } state_e;

    // Owner / last-owner encoding.
    localparam logic OwnIfu = 1'b0;
    localparam logic OwnLsu = 1'b1;

    // One extra bit so the comparison sees the incremented count without wrap.
    localparam logic [8:0] TimeoutLim = 9'(TIMEOUT);

    state_e                    state_q, state_d;
    logic                      owner_q, owner_d;
    logic                      last_q, last_d;
    logic [7:0]                cnt_q, cnt_d;
    logic                      we_q, we_d;
    logic [ISA_WIDTH-1:0]      addr_q, addr_d;
    logic [ISA_WIDTH-1:0]      wdata_q, wdata_d;
    logic [MEM_MASK_WIDTH-1:0] mask_q, mask_d;
    logic [ISA_WIDTH-1:0]      rdata_q, rdata_d;
    logic                      tmo_q, tmo_d;

    logic [8:0] cnt_inc;
    logic       pick_lsu;

    assign cnt_inc = {1'b0, cnt_q} + 9'd1;

    // Next-state, payload capture and grants.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        mask_d   = mask_q;
        rdata_d  = rdata_q;
        tmo_d    = tmo_q;
        pick_lsu = 1'b0;
        ifu_gnt  = 1'b0;
        lsu_gnt  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ifu_req || lsu_req) begin
                    // On a tie the requester that was not served last wins.
                    pick_lsu = lsu_req && (!ifu_req || (last_q == OwnIfu));
                    ifu_gnt  = !pick_lsu;
                    lsu_gnt  = pick_lsu;
                    owner_d  = pick_lsu ? OwnLsu : OwnIfu;
                    last_d   = pick_lsu ? OwnLsu : OwnIfu;
                    state_d  = StReq;
                    if (pick_lsu) begin
                        we_d    = lsu_we;
                        addr_d  = lsu_addr;
                        wdata_d = lsu_wdata;
                        mask_d  = lsu_mask;
                    end else begin
                        // Fetches are always full-word reads.
                        we_d    = 1'b0;
                        addr_d  = ifu_addr;
                        wdata_d = '0;
                        mask_d  = '1;
                    end
                end
            end

            StReq: begin
                if (mem_ready) begin
                    state_d = StWait;
                    cnt_d   = '0;
                    tmo_d   = 1'b0;
                end
            end

            StWait: begin
                // A response in the final allowed cycle beats the timeout.
                if (mem_rvalid) begin
                    rdata_d = we_q ? '0 : mem_rdata;
                    tmo_d   = 1'b0;
                    state_d = StResp;
                end else if (cnt_inc == TimeoutLim) begin
                    rdata_d = '0;
                    tmo_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_inc[7:0];
                end
            end

            StResp: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are decoded from state; payload is only exposed while it is meaningful.
    always_comb begin
        mem_valid  = (state_q == StReq);
        mem_we     = mem_valid && we_q;
        mem_addr   = mem_valid ? addr_q  : '0;
        mem_wdata  = mem_valid ? wdata_q : '0;
        mem_mask   = mem_valid ? mask_q  : '0;

        ifu_rvalid = (state_q == StResp) && (owner_q == OwnIfu);
        lsu_rvalid = (state_q == StResp) && (owner_q == OwnLsu);
        ifu_rdata  = ifu_rvalid ? rdata_q : '0;
        lsu_rdata  = lsu_rvalid ? rdata_q : '0;
        err        = (state_q == StResp) && tmo_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            owner_q <= OwnIfu;
            last_q  <= OwnIfu;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: a directed vector table, hand-written multi-cycle
// sequences (backpressure, timeout boundary, reset mid-transaction) and a randomized
// run checked against a transaction-level reference model.
module tb_mem_arb;

    localparam int unsigned AW  = 32;
    localparam int unsigned MW  = 4;
    localparam int unsigned TMO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifu_req;
    logic [AW-1:0] ifu_addr;
    logic          ifu_gnt, ifu_rvalid;
    logic [AW-1:0] ifu_rdata;
    logic          lsu_req, lsu_we;
    logic [AW-1:0] lsu_addr, lsu_wdata;
    logic [MW-1:0] lsu_mask;
    logic          lsu_gnt, lsu_rvalid;
    logic [AW-1:0] lsu_rdata;
    logic          mem_valid, mem_ready, mem_we;
    logic [AW-1:0] mem_addr, mem_wdata;
    logic [MW-1:0] mem_mask;
    logic          mem_rvalid;
    logic [AW-1:0] mem_rdata;
    logic          err;

    always #5 clk = ~clk;

    mem_arb #(
        .TIMEOUT       (TMO),
        .ISA_WIDTH     (AW),
        .MEM_MASK_WIDTH(MW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ifu_req   (ifu_req),
        .ifu_addr  (ifu_addr),
        .ifu_gnt   (ifu_gnt),
        .ifu_rvalid(ifu_rvalid),
        .ifu_rdata (ifu_rdata),
        .lsu_req   (lsu_req),
        .lsu_we    (lsu_we),
        .lsu_addr  (lsu_addr),
        .lsu_wdata (lsu_wdata),
        .lsu_mask  (lsu_mask),
        .lsu_gnt   (lsu_gnt),
        .lsu_rvalid(lsu_rvalid),
        .lsu_rdata (lsu_rdata),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_mask  (mem_mask),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .err       (err)
    );

    typedef struct {
        // stimulus
        logic          rst_n;
        logic          ireq;
        logic [31:0]   iaddr;
        logic          lreq;
        logic          lwe;
        logic [31:0]   laddr;
        logic [31:0]   lwdata;
        logic [3:0]    lmask;
        logic          rdy;
        logic          rv;
        logic [31:0]   rdata;
        // expected
        logic [1:0]    gnt;     // {lsu, ifu}
        logic          mv;
        logic          mwe;
        logic [31:0]   maddr;
        logic [31:0]   mwdata;
        logic [3:0]    mmask;
        logic [1:0]    rvld;    // {lsu, ifu}
        logic [31:0]   ordata;  // owner's rdata while rvalid
        logic          err;
    } vec_t;

    vec_t vecs[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [1:0] gnt, input logic mv,
                            input logic mwe, input logic [31:0] maddr,
                            input logic [31:0] mwdata, input logic [3:0] mmask,
                            input logic [1:0] rvld, input logic [31:0] ordata,
                            input logic e);
        chk({tag, ".gnt"}, 32'({lsu_gnt, ifu_gnt}), 32'(gnt));
        chk({tag, ".mem_valid"}, 32'(mem_valid), 32'(mv));
        if (mv) begin
            chk({tag, ".mem_we"}, 32'(mem_we), 32'(mwe));
            chk({tag, ".mem_addr"}, mem_addr, maddr);
            chk({tag, ".mem_wdata"}, mem_wdata, mwdata);
            chk({tag, ".mem_mask"}, 32'(mem_mask), 32'(mmask));
        end
        chk({tag, ".rvalid"}, 32'({lsu_rvalid, ifu_rvalid}), 32'(rvld));
        if (rvld[0]) chk({tag, ".ifu_rdata"}, ifu_rdata, ordata);
        if (rvld[1]) chk({tag, ".lsu_rdata"}, lsu_rdata, ordata);
        chk({tag, ".err"}, 32'(err), 32'(e));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        rst        = 1'b1;
        ifu_req    = 1'b0;
        ifu_addr   = '0;
        lsu_req    = 1'b0;
        lsu_we     = 1'b0;
        lsu_addr   = '0;
        lsu_wdata  = '0;
        lsu_mask   = '0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
    endtask

    // Random-phase model state.
    logic        m_last;     // 1 = LSU served last
    bit          m_open;
    bit          m_hs;
    int          m_gnt_cyc;
    logic        m_owner;
    logic        m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_mask;
    int          m_rv_cyc;
    logic [31:0] m_rdata;
    logic        m_err;
    int          rsp_cyc;
    logic [31:0] rsp_data;
    bit          drop_i, drop_l;
    logic        win_lsu;
    logic [1:0]  exp_gnt;
    logic        exp_mv;
    bit          stray_ok;
    int          dly, n_txn;

    // Timeout-sequence bookkeeping.
    int          rv_k, n_rv, n_irv, n_err_p, rv_at;
    logic [31:0] got_data;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        // ---------------- Directed vector table ----------------
        // Single IFU read with minimum latency.
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0,
            32'h0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 2'b00, 32'h0, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0,
            1'b0, 32'h0, 2'b01, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 2'b00, 32'h0, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0,
            32'h0, 2'b00, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'hF, 2'b00, 32'h0, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1,
            32'h0000_0413, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 2'b00, 32'h0, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0,
            32'h0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 2'b01, 32'h0000_0413, 1'b0});
        // Reset, then a tie: LSU byte store wins first.
        vecs.push_back(vec_t'{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0,
            32'h0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 2'b00, 32'h0, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 32'h8000_1003, 32'hAB, 4'h1,
            1'b0, 1'b0, 32'h0, 2'b10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 2'b00, 32'h0, 1'b0});
        // LSU payload churns after grant; the in-flight store must not change.
        vecs.push_back(vec_t'{1'b1, 1'b1, 32'h100, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF, 4'hF,
            1'b1, 1'b0, 32'h0, 2'b00, 1'b1, 1'b1, 32'h8000_1003, 32'hAB, 4'h1, 2'b00, 32'h0,
            1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1,
            32'hDEAD_BEEF, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 2'b00, 32'h0, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0,
            32'h0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 2'b10, 32'h0, 1'b0});
        // Second tie goes to IFU.
        vecs.push_back(vec_t'{1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'h55, 4'h3, 1'b0,
            1'b0, 32'h0, 2'b01, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 2'b00, 32'h0, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h55, 4'h3, 1'b1,
            1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 2'b00, 32'h0, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h55, 4'h3, 1'b0,
            1'b1, 32'h1234_5678, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 2'b00, 32'h0, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h55, 4'h3, 1'b0,
            1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 2'b01, 32'h1234_5678, 1'b0});
        // LSU read: wdata/mask pass through unchanged.
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h55, 4'h3, 1'b0,
            1'b0, 32'h0, 2'b10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 2'b00, 32'h0, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0,
            32'h0, 2'b00, 1'b1, 1'b0, 32'h200, 32'h55, 4'h3, 2'b00, 32'h0, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1,
            32'hCAFE_F00D, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 2'b00, 32'h0, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0,
            32'h0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 2'b10, 32'hCAFE_F00D, 1'b0});

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            rst        = vecs[i].rst_n;
            ifu_req    = vecs[i].ireq;
            ifu_addr   = vecs[i].iaddr;
            lsu_req    = vecs[i].lreq;
            lsu_we     = vecs[i].lwe;
            lsu_addr   = vecs[i].laddr;
            lsu_wdata  = vecs[i].lwdata;
            lsu_mask   = vecs[i].lmask;
            mem_ready  = vecs[i].rdy;
            mem_rvalid = vecs[i].rv;
            mem_rdata  = vecs[i].rdata;
            sample();
            chk_outs($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].mv, vecs[i].mwe,
                     vecs[i].maddr, vecs[i].mwdata, vecs[i].mmask, vecs[i].rvld,
                     vecs[i].ordata, vecs[i].err);
            next_cycle();
        end

        // ---------------- Backpressure: ready low for 5 cycles ----------------
        do_reset();
        ifu_req  = 1'b1;
        ifu_addr = 32'h0000_1000;
        sample();
        chk("bp.ifu_gnt", 32'(ifu_gnt), 32'd1);
        next_cycle();
        ifu_req  = 1'b0;
        lsu_req  = 1'b1;
        lsu_addr = 32'h0000_2000;
        for (int k = 0; k < 5; k++) begin
            ifu_addr = $urandom();
            sample();
            chk("bp.mem_valid", 32'(mem_valid), 32'd1);
            chk("bp.mem_addr", mem_addr, 32'h0000_1000);
            chk("bp.mem_mask", 32'(mem_mask), 32'hF);
            chk("bp.no_gnt", 32'({lsu_gnt, ifu_gnt}), 32'd0);
            next_cycle();
        end
        mem_ready = 1'b1;
        sample();
        chk("bp.hs_valid", 32'(mem_valid), 32'd1);
        chk("bp.hs_addr", mem_addr, 32'h0000_1000);
        next_cycle();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h77;
        sample();
        chk("bp.single_hs", 32'(mem_valid), 32'd0);
        chk("bp.wait_no_gnt", 32'({lsu_gnt, ifu_gnt}), 32'd0);
        next_cycle();
        mem_rvalid = 1'b0;
        sample();
        chk("bp.ifu_rvalid", 32'(ifu_rvalid), 32'd1);
        chk("bp.ifu_rdata", ifu_rdata, 32'h77);
        chk("bp.resp_no_gnt", 32'(lsu_gnt), 32'd0);
        next_cycle();
        sample();
        chk("bp.lsu_gnt_after", 32'(lsu_gnt), 32'd1);
        next_cycle();

        // ---------------- Timeout boundary: none / last WAIT cycle / in RESP --------------
        for (int c = 0; c < 3; c++) begin
            rv_k = (c == 0) ? -1 : ((c == 1) ? 4 : 5);
            do_reset();
            lsu_req   = 1'b1;
            lsu_addr  = 32'h300;
            lsu_mask  = 4'hF;
            mem_ready = 1'b1;
            sample();
            chk("tmo.lsu_gnt", 32'(lsu_gnt), 32'd1);
            next_cycle();
            lsu_req  = 1'b0;
            n_rv     = 0;
            n_irv    = 0;
            n_err_p  = 0;
            rv_at    = -1;
            got_data = 32'hFFFF_FFFF;
            for (int k = 0; k < 10; k++) begin
                mem_rvalid = (k == rv_k);
                mem_rdata  = 32'h0000_ABCD;
                sample();
                if (lsu_rvalid) begin
                    n_rv++;
                    rv_at    = k;
                    got_data = lsu_rdata;
                end
                if (ifu_rvalid) n_irv++;
                if (err) n_err_p++;
                next_cycle();
            end
            mem_rvalid = 1'b0;
            chk($sformatf("tmo%0d.rv_count", c), 32'(n_rv), 32'd1);
            chk($sformatf("tmo%0d.rv_cycle", c), 32'(rv_at), 32'd5);
            chk($sformatf("tmo%0d.rdata", c), got_data, (c == 1) ? 32'h0000_ABCD : 32'h0);
            chk($sformatf("tmo%0d.err_count", c), 32'(n_err_p), (c == 1) ? 32'd0 : 32'd1);
            chk($sformatf("tmo%0d.ifu_rv", c), 32'(n_irv), 32'd0);
            ifu_req = 1'b1;
            sample();
            chk($sformatf("tmo%0d.idle_gnt", c), 32'(ifu_gnt), 32'd1);
            next_cycle();
            ifu_req = 1'b0;
        end

        // ---------------- Reset while in WAIT, late response ignored ----------------
        do_reset();
        ifu_req   = 1'b1;
        ifu_addr  = 32'h400;
        mem_ready = 1'b1;
        sample();
        chk("rw.gnt", 32'(ifu_gnt), 32'd1);
        next_cycle();
        ifu_req = 1'b0;
        sample();
        chk("rw.mem_valid", 32'(mem_valid), 32'd1);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            mem_rvalid = (k == 1);
            mem_rdata  = 32'h999;
            sample();
            chk_outs($sformatf("rw.quiet%0d", k), 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
                     2'b00, 32'h0, 1'b0);
            chk("rw.mem_addr_zero", mem_addr, 32'h0);
            next_cycle();
        end
        mem_rvalid = 1'b0;
        ifu_req    = 1'b1;
        ifu_addr   = 32'h500;
        sample();
        chk_outs("rw.g", 2'b01, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 2'b00, 32'h0, 1'b0);
        next_cycle();
        ifu_req = 1'b0;
        sample();
        chk_outs("rw.r", 2'b00, 1'b1, 1'b0, 32'h500, 32'h0, 4'hF, 2'b00, 32'h0, 1'b0);
        next_cycle();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h600;
        sample();
        chk_outs("rw.w", 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 2'b00, 32'h0, 1'b0);
        next_cycle();
        mem_rvalid = 1'b0;
        sample();
        chk_outs("rw.p", 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 2'b01, 32'h600, 1'b0);
        next_cycle();

        // ---------------- Randomized run vs. transaction-level model ----------------
        do_reset();
        m_last   = 1'b0;
        m_open   = 0;
        m_hs     = 0;
        m_rv_cyc = -1;
        rsp_cyc  = -1;
        drop_i   = 0;
        drop_l   = 0;
        n_txn    = 0;
        for (int t = 0; t < 3000; t++) begin
            if (drop_i) begin ifu_req = 1'b0; drop_i = 0; end
            if (drop_l) begin lsu_req = 1'b0; drop_l = 0; end
            // Payload may wander freely while not requesting.
            if (!ifu_req) begin
                ifu_addr = $urandom();
                ifu_req  = ($urandom_range(0, 2) == 0);
            end
            if (!lsu_req) begin
                lsu_we    = 1'($urandom_range(0, 1));
                lsu_addr  = $urandom();
                lsu_wdata = $urandom();
                lsu_mask  = 4'($urandom_range(0, 15));
                lsu_req   = ($urandom_range(0, 2) == 0);
            end
            mem_ready  = ($urandom_range(0, 9) < 6);
            // Stray responses only where nothing is being waited for.
            stray_ok   = !m_open || !m_hs || (cyc == m_rv_cyc);
            mem_rvalid = (cyc == rsp_cyc) || (stray_ok && ($urandom_range(0, 7) == 0));
            mem_rdata  = (cyc == rsp_cyc) ? rsp_data : $urandom();
            sample();

            exp_gnt = 2'b00;
            if (!m_open && (ifu_req || lsu_req)) begin
                win_lsu   = lsu_req && (!ifu_req || !m_last);
                exp_gnt   = win_lsu ? 2'b10 : 2'b01;
                m_last    = win_lsu;
                m_owner   = win_lsu;
                m_we      = win_lsu ? lsu_we : 1'b0;
                m_addr    = win_lsu ? lsu_addr : ifu_addr;
                m_wdata   = win_lsu ? lsu_wdata : 32'h0;
                m_mask    = win_lsu ? lsu_mask : 4'hF;
                m_open    = 1;
                m_hs      = 0;
                m_gnt_cyc = cyc;
                drop_i    = !win_lsu;
                drop_l    = win_lsu;
            end
            chk("rand.gnt", 32'({lsu_gnt, ifu_gnt}), 32'(exp_gnt));

            exp_mv = m_open && !m_hs && (cyc > m_gnt_cyc);
            chk("rand.mem_valid", 32'(mem_valid), 32'(exp_mv));
            if (exp_mv) begin
                chk("rand.mem_we", 32'(mem_we), 32'(m_we));
                chk("rand.mem_addr", mem_addr, m_addr);
                chk("rand.mem_wdata", mem_wdata, m_wdata);
                chk("rand.mem_mask", 32'(mem_mask), 32'(m_mask));
                if (mem_ready) begin
                    // WAIT cycle j (j = 0 first) is cyc+1+j; TMO WAIT cycles allowed.
                    m_hs     = 1;
                    dly      = int'($urandom_range(0, 6));
                    rsp_cyc  = cyc + 1 + dly;
                    rsp_data = $urandom();
                    if (dly < int'(TMO)) begin
                        m_rv_cyc = cyc + 2 + dly;
                        m_rdata  = m_we ? 32'h0 : rsp_data;
                        m_err    = 1'b0;
                    end else begin
                        m_rv_cyc = cyc + 1 + int'(TMO);
                        m_rdata  = 32'h0;
                        m_err    = 1'b1;
                    end
                end
            end

            if (m_open && m_hs && (cyc == m_rv_cyc)) begin
                chk("rand.rvalid", 32'({lsu_rvalid, ifu_rvalid}),
                    m_owner ? 32'd2 : 32'd1);
                chk("rand.rdata", m_owner ? lsu_rdata : ifu_rdata, m_rdata);
                chk("rand.err", 32'(err), 32'(m_err));
                m_open = 0;
                n_txn++;
            end else begin
                chk("rand.rvalid", 32'({lsu_rvalid, ifu_rvalid}), 32'd0);
                chk("rand.err", 32'(err), 32'd0);
            end
            next_cycle();
        end
        chk("rand.progress", 32'(n_txn > 100), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
